// File: rtl/fp_regfile_sb.sv
// FP register file with NRD combinational read ports, NWR prioritised write ports,
// write-to-read bypass and a per-register busy scoreboard with issue-time WAW guard.
module fp_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 3,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_idx,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_vld,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_stall,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             iss_wr_hit;
  logic             iss_accept;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int r = 0; r < NREGS; r++) cnt += {{AW{1'b0}}, v[r]};
    return cnt;
  endfunction

  // Ports are scanned in ascending order so the highest-numbered matching write wins.
  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs[rd_idx[i*AW +: AW]];
      rd_busy[i]              = busy[rd_idx[i*AW +: AW]];
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_idx[p*AW +: AW] == rd_idx[i*AW +: AW])) begin
          rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
          rd_busy[i]              = 1'b0;
        end
      end
    end
  end

  always_comb begin
    iss_wr_hit = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_idx[p*AW +: AW] == iss_rd)) iss_wr_hit = 1'b1;
    end
  end

  // A register may have only one outstanding producer; a retiring write frees it this cycle.
  assign iss_stall  = iss_vld & busy[iss_rd] & ~iss_wr_hit;
  assign iss_accept = iss_vld & ~iss_stall;

  // Clears are applied first so an accepted issue to the same register wins.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) busy_nxt[wr_idx[p*AW +: AW]] = 1'b0;
    end
    if (iss_accept) busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset explicitly because readers rely on a defined value after reset.
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates sampling pre-edge values.
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p]) regs[wr_idx[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
      busy     <= busy_nxt;
      pend_cnt <= popcount(busy);
    end
  end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed bench for fp_regfile_sb: table of read/write/bypass vectors plus
// hand-written scoreboard, WAW, full-occupancy and mid-operation reset sequences.
module tb_fp_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_idx;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_idx;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_vld;
  logic [AW-1:0]       iss_rd;
  logic                iss_stall;
  logic [AW:0]         pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fp_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .iss_vld(iss_vld), .iss_rd(iss_rd), .iss_stall(iss_stall),
    .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wi0, wi1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ri0, ri1, ri2;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_wr(input logic [1:0] en, input logic [4:0] i0, input logic [4:0] i1,
                          input logic [31:0] d0, input logic [31:0] d1);
    wr_en   = en;
    wr_idx  = {i1, i0};
    wr_data = {d1, d0};
  endtask

  task automatic set_rd(input logic [4:0] i0, input logic [4:0] i1, input logic [4:0] i2);
    rd_idx = {i2, i1, i0};
  endtask

  task automatic idle();
    drive_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    iss_vld = 1'b0;
    iss_rd  = '0;
  endtask

  function automatic logic [31:0] rdd(input int i);
    return rd_data[i*XLEN +: XLEN];
  endfunction

  initial begin
    vecs[0] = '{2'b11, 5'd7,  5'd7,  32'h3F800000, 32'h40000000, 5'd7,  5'd0, 5'd5,
                32'h40000000, 32'h0,        32'h0};
    vecs[1] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7,  5'd0, 5'd1,
                32'h40000000, 32'h0,        32'h0};
    vecs[2] = '{2'b01, 5'd0,  5'd0,  32'hAAAA5555, 32'h0,        5'd0,  5'd7, 5'd0,
                32'hAAAA5555, 32'h40000000, 32'hAAAA5555};
    vecs[3] = '{2'b10, 5'd31, 5'd31, 32'h11111111, 32'hDEADBEEF, 5'd31, 5'd0, 5'd2,
                32'hDEADBEEF, 32'hAAAA5555, 32'h0};
    vecs[4] = '{2'b11, 5'd2,  5'd9,  32'h12345678, 32'hCAFEF00D, 5'd2,  5'd9, 5'd31,
                32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[5] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd2,  5'd9, 5'd7,
                32'h12345678, 32'hCAFEF00D, 32'h40000000};
    vecs[6] = '{2'b01, 5'd7,  5'd0,  32'h3F800000, 32'h0,        5'd7,  5'd7, 5'd0,
                32'h3F800000, 32'h3F800000, 32'hAAAA5555};
    vecs[7] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7,  5'd31, 5'd0,
                32'h3F800000, 32'hDEADBEEF, 32'hAAAA5555};

    // Reset for two cycles, then read.
    rst = 1'b1;
    idle();
    set_rd(5'd5, 5'd0, 5'd31);
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("reset rd_data0", rdd(0), 32'h0);
    check("reset rd_data1", rdd(1), 32'h0);
    check("reset rd_data2", rdd(2), 32'h0);
    check("reset rd_busy", rd_busy, 3'b000);
    check("reset pend_cnt", pend_cnt, 6'd0);
    check("reset iss_stall", iss_stall, 1'b0);

    // Table: writes, bypass, port priority, disabled-port isolation.
    for (int v = 0; v < 8; v++) begin
      drive_wr(vecs[v].we, vecs[v].wi0, vecs[v].wi1, vecs[v].wd0, vecs[v].wd1);
      set_rd(vecs[v].ri0, vecs[v].ri1, vecs[v].ri2);
      settle();
      check($sformatf("vec%0d rd_data0", v), rdd(0), vecs[v].e0);
      check($sformatf("vec%0d rd_data1", v), rdd(1), vecs[v].e1);
      check($sformatf("vec%0d rd_data2", v), rdd(2), vecs[v].e2);
      check($sformatf("vec%0d rd_busy", v), rd_busy, 3'b000);
      tick();
    end
    idle();

    // Scoreboard RAW on f3.
    iss_vld = 1'b1;
    iss_rd  = 5'd3;
    set_rd(5'd0, 5'd3, 5'd0);
    settle();
    check("raw issue stall", iss_stall, 1'b0);
    check("raw same-cycle rd_busy", rd_busy[1], 1'b0);
    tick();
    idle();
    settle();
    check("raw busy seen", rd_busy[1], 1'b1);
    check("raw pend_cnt lag", pend_cnt, 6'd0);
    tick();
    check("raw pend_cnt 1", pend_cnt, 6'd1);
    drive_wr(2'b01, 5'd3, 5'd0, 32'h41200000, 32'h0);
    settle();
    check("raw bypass busy", rd_busy[1], 1'b0);
    check("raw bypass data", rdd(1), 32'h41200000);
    tick();
    idle();
    settle();
    check("raw busy cleared", rd_busy[1], 1'b0);
    check("raw data stored", rdd(1), 32'h41200000);
    tick();
    check("raw pend_cnt 0", pend_cnt, 6'd0);

    // WAW guard on f4.
    iss_vld = 1'b1;
    iss_rd  = 5'd4;
    tick();
    settle();
    check("waw stall", iss_stall, 1'b1);
    tick();
    tick();
    check("waw pend unchanged", pend_cnt, 6'd1);
    drive_wr(2'b10, 5'd0, 5'd4, 32'h0, 32'h40400000);
    settle();
    check("waw stall released", iss_stall, 1'b0);
    tick();
    idle();
    set_rd(5'd4, 5'd0, 5'd0);
    settle();
    check("waw set wins", rd_busy[0], 1'b1);
    check("waw data landed", rdd(0), 32'h40400000);
    tick();
    check("waw pend still 1", pend_cnt, 6'd1);
    drive_wr(2'b01, 5'd4, 5'd0, 32'h40400000, 32'h0);
    tick();
    idle();
    tick();
    check("waw drained", pend_cnt, 6'd0);

    // Full occupancy: issue every register, then write all back two per cycle.
    for (int r = 0; r < NREGS; r++) begin
      iss_vld = 1'b1;
      iss_rd  = AW'(r);
      settle();
      check($sformatf("full issue %0d stall", r), iss_stall, 1'b0);
      tick();
    end
    idle();
    tick();
    check("full pend_cnt 32", pend_cnt, 6'd32);
    set_rd(5'd0, 5'd15, 5'd31);
    settle();
    check("full rd_busy", rd_busy, 3'b111);
    for (int k = 0; k < NREGS / 2; k++) begin
      drive_wr(2'b11, AW'(2 * k), AW'(2 * k + 1), 32'h10000000 + 32'(2 * k),
               32'h10000000 + 32'(2 * k + 1));
      tick();
      if (k == 7) check("full pend after 8 writes", pend_cnt, 6'd18);
    end
    idle();
    check("full pend after 16 writes", pend_cnt, 6'd2);
    tick();
    check("full pend drained", pend_cnt, 6'd0);
    set_rd(5'd0, 5'd17, 5'd31);
    settle();
    check("full readback0", rdd(0), 32'h10000000);
    check("full readback1", rdd(1), 32'h10000011);
    check("full readback2", rdd(2), 32'h1000001F);
    check("full busy clear", rd_busy, 3'b000);

    // Reset mid-operation with five registers busy and a write and an issue pending.
    for (int r = 10; r < 15; r++) begin
      iss_vld = 1'b1;
      iss_rd  = AW'(r);
      tick();
    end
    idle();
    tick();
    check("midrst pend before", pend_cnt, 6'd5);
    rst     = 1'b1;
    iss_vld = 1'b1;
    iss_rd  = 5'd21;
    drive_wr(2'b01, 5'd20, 5'd0, 32'hFFFFFFFF, 32'h0);
    set_rd(5'd20, 5'd10, 5'd21);
    settle();
    check("midrst bypass in reset", rdd(0), 32'hFFFFFFFF);
    tick();
    rst = 1'b0;
    idle();
    settle();
    check("midrst write discarded", rdd(0), 32'h0);
    check("midrst reg10 cleared", rdd(1), 32'h0);
    check("midrst rd_busy", rd_busy, 3'b000);
    check("midrst pend_cnt", pend_cnt, 6'd0);
    set_rd(5'd0, 5'd31, 5'd4);
    settle();
    check("midrst reg0 cleared", rdd(0), 32'h0);
    check("midrst reg31 cleared", rdd(1), 32'h0);
    tick();
    check("midrst pend stays 0", pend_cnt, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
